// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and mode constants,
// common to the master and the existing slave blocks.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TRAIL = 3'd3,
      ST_DONE  = 3'd4
   } spi_state_e;

   localparam bit SPI_LSB_FIRST  = 1'b1;
   localparam bit SPI_MSB_FIRST  = 1'b0;
   localparam bit SPI_MODE0_CPOL = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk edge on which sclk will rise or fall.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic no_rise,
   output logic sclk,
   output logic tick,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   // no_rise lets the half-period timer keep running with sclk parked low
   assign tick = en && (div_cnt == '0);
   assign rise = tick && !sclk && !no_rise;
   assign fall = tick && sclk;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         sclk    <= SPI_MODE0_CPOL;
      end else if (!en) begin
         div_cnt <= RELOAD;
         sclk    <= SPI_MODE0_CPOL;
      end else if (tick) begin
         div_cnt <= RELOAD;
         if (rise || fall) sclk <= ~sclk;
      end else begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_daisy_master.sv
// Daisy-chain SPI master, mode 0: one FRAME_W-bit frame per start, shared
// chip select, returned data taken from the last device in the chain.
//
// state    | meaning
// ST_IDLE  | cs high, sclk low, waiting for start
// ST_LEAD  | cs low, one half-period before the first sclk rise
// ST_SHIFT | FRAME_W sclk periods: sample sdi on rise, next sdo on fall
// ST_TRAIL | cs low, sclk parked low for one half-period
// ST_DONE  | cs high, one-cycle done pulse, dout updated
module spi_daisy_master
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int N_DEV     = 2,
   parameter int CLK_DIV   = 4,
   parameter bit LSB_FIRST = SPI_LSB_FIRST,
   localparam int FRAME_W  = N_DEV * DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] din,
   input  logic               sdi,
   output logic               sdo,
   output logic               sclk,
   output logic               cs,
   output logic               busy,
   output logic               done,
   output logic [FRAME_W-1:0] dout
);

   localparam int CNT_W = $clog2(FRAME_W + 1);

   if (DATA_W < 1 || N_DEV < 1 || CLK_DIV < 1) begin : g_bad_param
      $error("spi_daisy_master: DATA_W, N_DEV and CLK_DIV must all be at least 1");
   end

   spi_state_e         state, state_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] tx_sr, rx_sr;
   logic               sclk_en, no_rise, tick, rise, fall;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (sclk_en),
      .no_rise (no_rise),
      .sclk    (sclk),
      .tick    (tick),
      .rise    (rise),
      .fall    (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sclk_en   = 1'b0;
      no_rise   = 1'b0;
      cs        = 1'b1;
      busy      = (state != ST_IDLE);
      done      = 1'b0;
      unique case (state)
         ST_IDLE: if (start) state_nxt = ST_LEAD;
         ST_LEAD: begin
            sclk_en = 1'b1;
            cs      = 1'b0;
            if (tick) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            sclk_en = 1'b1;
            cs      = 1'b0;
            no_rise = (bit_cnt == '0);
            // leave after the low phase that follows the last falling edge
            if (tick && !sclk && bit_cnt == '0) state_nxt = ST_TRAIL;
         end
         ST_TRAIL: begin
            sclk_en = 1'b1;
            cs      = 1'b0;
            no_rise = 1'b1;
            if (tick) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sdo     <= 1'b0;
         dout    <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            bit_cnt <= CNT_W'(FRAME_W);
            rx_sr   <= '0;
            if (LSB_FIRST) begin
               tx_sr <= din >> 1;
               sdo   <= din[0];
            end else begin
               tx_sr <= din << 1;
               sdo   <= din[FRAME_W-1];
            end
         end
         if (rise) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            if (LSB_FIRST) rx_sr <= (rx_sr >> 1) | (FRAME_W'(sdi) << (FRAME_W - 1));
            else           rx_sr <= (rx_sr << 1) | FRAME_W'(sdi);
         end
         if (fall) begin
            if (LSB_FIRST) begin
               sdo   <= tx_sr[0];
               tx_sr <= tx_sr >> 1;
            end else begin
               sdo   <= tx_sr[FRAME_W-1];
               tx_sr <= tx_sr << 1;
            end
         end
         if (state == ST_TRAIL && tick) begin
            dout <= rx_sr;
            sdo  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_daisy_master.sv
// Bench for spi_daisy_master: default build with loopback or two chained
// 8-bit slaves, plus a CLK_DIV=1 single-device MSB-first build in loopback.
module tb_spi_daisy_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     = 1'b1;
   logic        start_a = 1'b1;
   logic        start_b = 1'b1;
   logic [15:0] din_a   = '0;
   logic [7:0]  din_b   = '0;
   logic        sdi_a, sdo_a, sclk_a, cs_a, busy_a, done_a;
   logic [15:0] dout_a;
   logic        sdi_b, sdo_b, sclk_b, cs_b, busy_b, done_b;
   logic [7:0]  dout_b;

   bit          chain_mode = 1'b0;
   logic [7:0]  dev1 = '0, dev2 = '0;
   logic        cap1 = 1'b0, cap2 = 1'b0;
   logic        prev_sclk_a = 1'b0, prev_sdo_a = 1'b0;
   logic        prev_sclk_b = 1'b0, prev_sdo_b = 1'b0;
   logic [15:0] chain_prev = '0;
   int          rise_a = 0, rise_b = 0, done_cnt_a = 0, done_cnt_b = 0;
   int          checks = 0, errors = 0;

   assign sdi_a = chain_mode ? dev2[0] : sdo_a;
   assign sdi_b = sdo_b;

   spi_daisy_master u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .din(din_a), .sdi(sdi_a),
      .sdo(sdo_a), .sclk(sclk_a), .cs(cs_a), .busy(busy_a), .done(done_a), .dout(dout_a)
   );

   spi_daisy_master #(.DATA_W(8), .N_DEV(1), .CLK_DIV(1), .LSB_FIRST(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .din(din_b), .sdi(sdi_b),
      .sdo(sdo_b), .sclk(sclk_b), .cs(cs_b), .busy(busy_b), .done(done_b), .dout(dout_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clk cycle; afterwards watch the serial pins and advance the slave chain.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      chk("a_sclk_low_when_cs_high", 32'(cs_a & sclk_a), 32'(0));
      chk("b_sclk_low_when_cs_high", 32'(cs_b & sclk_b), 32'(0));
      if (sclk_a && !prev_sclk_a) begin
         chk("a_sdo_stable_on_rise", 32'(sdo_a), 32'(prev_sdo_a));
         if (!cs_a) begin
            rise_a++;
            cap1 = sdo_a;
            cap2 = dev1[0];
         end
      end
      if (!sclk_a && prev_sclk_a && !cs_a) begin
         dev1 = {cap1, dev1[7:1]};
         dev2 = {cap2, dev2[7:1]};
      end
      if (sclk_b && !prev_sclk_b) begin
         chk("b_sdo_stable_on_rise", 32'(sdo_b), 32'(prev_sdo_b));
         if (!cs_b) rise_b++;
      end
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      prev_sclk_a = sclk_a;
      prev_sdo_a  = sdo_a;
      prev_sclk_b = sclk_b;
      prev_sdo_b  = sdo_b;
   endtask

   task automatic run_frame(input bit inst, input logic [15:0] d, input bit restart);
      logic [31:0] expv, hold;
      int          lat, fw, n;
      bit          got;
      lat = inst ? 18 : 136;
      fw  = inst ? 8 : 16;
      if (inst)            expv = 32'(d[7:0]);
      else if (chain_mode) expv = 32'(chain_prev);
      else                 expv = 32'(d);
      hold = inst ? 32'(dout_b) : 32'(dout_a);
      rise_a = 0; rise_b = 0; done_cnt_a = 0; done_cnt_b = 0;
      if (inst) begin din_b = d[7:0]; start_b = 1'b1; end
      else      begin din_a = d;      start_a = 1'b1; end
      step();
      start_a = 1'b0;
      start_b = 1'b0;
      chk("busy_after_start", inst ? 32'(busy_b) : 32'(busy_a), 32'(1));
      chk("first_sdo_bit", inst ? 32'(sdo_b) : 32'(sdo_a), inst ? 32'(d[7]) : 32'(d[0]));
      n   = 0;
      got = 1'b0;
      while (!got && n < lat + 40) begin
         if (restart && n == 10) begin
            if (inst) start_b = 1'b1;
            else      start_a = 1'b1;
         end
         step();
         n++;
         start_a = 1'b0;
         start_b = 1'b0;
         if (inst ? done_b : done_a) got = 1'b1;
         else chk("dout_held_while_busy", inst ? 32'(dout_b) : 32'(dout_a), hold);
      end
      chk("done_seen", 32'(got), 32'(1));
      chk("done_latency", 32'(n), 32'(lat));
      chk("dout_frame", inst ? 32'(dout_b) : 32'(dout_a), expv);
      chk("rise_count", inst ? 32'(rise_b) : 32'(rise_a), 32'(fw));
      repeat (3) step();
      chk("done_pulse_count", inst ? 32'(done_cnt_b) : 32'(done_cnt_a), 32'(1));
      chk("idle_busy", inst ? 32'(busy_b) : 32'(busy_a), 32'(0));
      chk("idle_cs", inst ? 32'(cs_b) : 32'(cs_a), 32'(1));
      chk("idle_sdo", inst ? 32'(sdo_b) : 32'(sdo_a), 32'(0));
      if (!inst) chain_prev = d;
   endtask

   initial begin
      // start raised while rst is high must be dropped
      repeat (2) step();
      rst     = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      step();
      chk("rst_busy_a", 32'(busy_a), 32'(0));
      chk("rst_busy_b", 32'(busy_b), 32'(0));
      chk("rst_cs_a", 32'(cs_a), 32'(1));
      chk("rst_sclk_a", 32'(sclk_a), 32'(0));
      chk("rst_sdo_a", 32'(sdo_a), 32'(0));
      chk("rst_done_a", 32'(done_a), 32'(0));
      chk("rst_dout_a", 32'(dout_a), 32'(0));
      chk("rst_cs_b", 32'(cs_b), 32'(1));
      chk("rst_dout_b", 32'(dout_b), 32'(0));

      run_frame(1'b0, 16'hA55A, 1'b0);

      chain_mode = 1'b1;
      dev1 = '0; dev2 = '0; cap1 = 1'b0; cap2 = 1'b0;
      chain_prev = '0;
      run_frame(1'b0, 16'h1234, 1'b0);
      run_frame(1'b0, 16'hBEEF, 1'b0);

      chain_mode = 1'b0;
      run_frame(1'b0, 16'($urandom), 1'b1);

      for (int i = 0; i < 6; i++) begin
         chain_mode = 1'($urandom_range(0, 1));
         run_frame(1'b0, 16'($urandom), 1'b0);
      end

      chain_mode = 1'b0;
      din_a      = 16'($urandom);
      start_a    = 1'b1;
      step();
      start_a = 1'b0;
      repeat (40) step();
      chk("mid_frame_busy", 32'(busy_a), 32'(1));
      rst = 1'b1;
      step();
      chk("mid_rst_cs", 32'(cs_a), 32'(1));
      chk("mid_rst_sclk", 32'(sclk_a), 32'(0));
      chk("mid_rst_busy", 32'(busy_a), 32'(0));
      chk("mid_rst_done", 32'(done_a), 32'(0));
      chk("mid_rst_sdo", 32'(sdo_a), 32'(0));
      chk("mid_rst_dout", 32'(dout_a), 32'(0));
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("post_rst_busy", 32'(busy_a), 32'(0));
      dev1 = '0; dev2 = '0; cap1 = 1'b0; cap2 = 1'b0;
      chain_prev = '0;
      run_frame(1'b0, 16'($urandom), 1'b0);

      run_frame(1'b1, 16'h0081, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_frame(1'b1, 16'($urandom_range(0, 255)), (i == 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
